// File: rtl/axi_rab_pkg.sv
// Shared types and defaults for the RAB AXI4 read-address sequencing logic.
package axi_rab_pkg;

  typedef enum logic [2:0] {
    AR_IDLE      = 3'd0,
    AR_LOOKUP    = 3'd1,
    AR_ACCEPT    = 3'd2,
    AR_DROP      = 3'd3,
    AR_WAIT_SENT = 3'd4
  } ar_state_e;

  localparam int unsigned LOOKUP_TIMEOUT_DEFAULT = 64;
  localparam int unsigned MISS_CNT_WIDTH         = 16;

  function automatic logic [MISS_CNT_WIDTH-1:0] sat_inc(input logic [MISS_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + MISS_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/axi4_drop_desc_reg.sv
// Drop descriptor register: holds ID/length for the R-channel error responder
// until the responder takes it while the master still presents the AR.
module axi4_drop_desc_reg #(
  parameter int unsigned ID_W  = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [ID_W-1:0]  id_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             ready_i,
  input  logic             arvalid_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  id_o,
  output logic [LEN_W-1:0] len_o,
  output logic             fire_o
);

  logic             valid_q;
  logic [ID_W-1:0]  id_q;
  logic [LEN_W-1:0] len_q;

  // The drop completes only when the AR it refers to is still on the bus.
  assign fire_o  = valid_q & ready_i & arvalid_i;
  assign valid_o = valid_q;
  assign id_o    = id_q;
  assign len_o   = len_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      len_q   <= '0;
    end else if (load_i && !valid_q) begin
      valid_q <= 1'b1;
      id_q    <= id_i;
      len_q   <= len_i;
    end else if (fire_o) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axi4_arch_lookup_ctrl.sv
// AR sequencing controller: captures an AR, runs one translation lookup and
// either forwards it to the AR sender or drops it to the error responder.
module axi4_arch_lookup_ctrl
  import axi_rab_pkg::*;
#(
  parameter int unsigned C_AXI_ID_WIDTH   = 4,
  parameter int unsigned C_LOOKUP_TIMEOUT = LOOKUP_TIMEOUT_DEFAULT
) (
  input  logic                      axi4_aclk,
  input  logic                      axi4_arstn,
  input  logic                      s_axi4_arvalid,
  input  logic [C_AXI_ID_WIDTH-1:0] s_axi4_arid,
  input  logic [31:0]               s_axi4_araddr,
  input  logic [7:0]                s_axi4_arlen,
  input  logic                      trans_sent,
  output logic                      trans_accept,
  output logic                      trans_drop,
  output logic                      lookup_req,
  output logic [31:0]               lookup_addr,
  input  logic                      lookup_done,
  input  logic                      lookup_hit,
  input  logic                      lookup_prot,
  output logic                      drop_valid,
  output logic [C_AXI_ID_WIDTH-1:0] drop_id,
  output logic [7:0]                drop_len,
  input  logic                      drop_ready,
  output logic                      miss_irq,
  output logic [31:0]               miss_addr,
  output logic [MISS_CNT_WIDTH-1:0] miss_cnt
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(C_LOOKUP_TIMEOUT - 1);

  ar_state_e                 state_q, state_d;
  logic [31:0]               addr_q;
  logic [C_AXI_ID_WIDTH-1:0] id_q;
  logic [7:0]                len_q;
  logic [7:0]                tcnt_q;
  logic                      accept_q;
  logic [31:0]               miss_addr_q;
  logic [MISS_CNT_WIDTH-1:0] miss_cnt_q;

  logic capture;
  logic drop_load;
  logic drop_fire;

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    drop_load = 1'b0;
    case (state_q)
      AR_IDLE: begin
        if (s_axi4_arvalid) begin
          capture = 1'b1;
          state_d = AR_LOOKUP;
        end
      end
      AR_LOOKUP: begin
        // A result in the final timeout cycle still wins over the timeout.
        if (lookup_done) begin
          state_d = (lookup_hit && !lookup_prot) ? AR_ACCEPT : AR_DROP;
        end else if (tcnt_q == TIMEOUT_LAST) begin
          state_d = AR_DROP;
        end
        drop_load = (state_d == AR_DROP);
      end
      AR_ACCEPT:    state_d = trans_sent ? AR_IDLE : AR_WAIT_SENT;
      AR_WAIT_SENT: if (trans_sent) state_d = AR_IDLE;
      AR_DROP:      if (drop_fire) state_d = AR_IDLE;
      default:      state_d = AR_IDLE;
    endcase
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      state_q  <= AR_IDLE;
      addr_q   <= '0;
      id_q     <= '0;
      len_q    <= '0;
      tcnt_q   <= '0;
      accept_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      accept_q <= (state_d == AR_ACCEPT);
      if (capture) begin
        addr_q <= s_axi4_araddr;
        id_q   <= s_axi4_arid;
        len_q  <= s_axi4_arlen;
        tcnt_q <= '0;
      end else if (state_q == AR_LOOKUP) begin
        tcnt_q <= tcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      miss_addr_q <= '0;
      miss_cnt_q  <= '0;
    end else if (drop_fire) begin
      miss_addr_q <= addr_q;
      miss_cnt_q  <= sat_inc(miss_cnt_q);
    end
  end

  axi4_drop_desc_reg #(
    .ID_W  (C_AXI_ID_WIDTH),
    .LEN_W (8)
  ) u_drop_desc (
    .clk_i     (axi4_aclk),
    .rst_ni    (axi4_arstn),
    .load_i    (drop_load),
    .id_i      (id_q),
    .len_i     (len_q),
    .ready_i   (drop_ready),
    .arvalid_i (s_axi4_arvalid),
    .valid_o   (drop_valid),
    .id_o      (drop_id),
    .len_o     (drop_len),
    .fire_o    (drop_fire)
  );

  assign lookup_req   = (state_q == AR_LOOKUP);
  assign lookup_addr  = addr_q;
  assign trans_accept = accept_q;
  assign trans_drop   = drop_fire;
  assign miss_irq     = drop_fire;
  assign miss_addr    = miss_addr_q;
  assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_axi4_arch_lookup_ctrl.sv
// Directed bench for axi4_arch_lookup_ctrl with a scoreboard of expected accept/drop events.
module tb_axi4_arch_lookup_ctrl;

  logic        clk;
  logic        rst_n;
  logic        arvalid;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        trans_sent;
  logic        trans_accept;
  logic        trans_drop;
  logic        lookup_req;
  logic [31:0] lookup_addr;
  logic        lookup_done;
  logic        lookup_hit;
  logic        lookup_prot;
  logic        drop_valid;
  logic [3:0]  drop_id;
  logic [7:0]  drop_len;
  logic        drop_ready;
  logic        miss_irq;
  logic [31:0] miss_addr;
  logic [15:0] miss_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        is_drop;
    logic [3:0]  id;
    logic [7:0]  len;
    logic [31:0] addr;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic        pend;
  logic [15:0] pend_cnt;
  logic [31:0] pend_addr;

  axi4_arch_lookup_ctrl #(
    .C_AXI_ID_WIDTH   (4),
    .C_LOOKUP_TIMEOUT (8)
  ) dut (
    .axi4_aclk      (clk),
    .axi4_arstn     (rst_n),
    .s_axi4_arvalid (arvalid),
    .s_axi4_arid    (arid),
    .s_axi4_araddr  (araddr),
    .s_axi4_arlen   (arlen),
    .trans_sent     (trans_sent),
    .trans_accept   (trans_accept),
    .trans_drop     (trans_drop),
    .lookup_req     (lookup_req),
    .lookup_addr    (lookup_addr),
    .lookup_done    (lookup_done),
    .lookup_hit     (lookup_hit),
    .lookup_prot    (lookup_prot),
    .drop_valid     (drop_valid),
    .drop_id        (drop_id),
    .drop_len       (drop_len),
    .drop_ready     (drop_ready),
    .miss_irq       (miss_irq),
    .miss_addr      (miss_addr),
    .miss_cnt       (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ar(input logic v, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    arvalid = v;
    araddr  = a;
    arid    = id;
    arlen   = len;
  endtask

  task automatic push_accept(input logic [31:0] a);
    exp_t e;
    e = '{is_drop: 1'b0, id: 4'h0, len: 8'h00, addr: a, cnt: 16'h0};
    sb.push_back(e);
  endtask

  task automatic push_drop(input logic [3:0] id, input logic [7:0] len, input logic [31:0] a,
                           input logic [15:0] cnt);
    exp_t e;
    e = '{is_drop: 1'b1, id: id, len: len, addr: a, cnt: cnt};
    sb.push_back(e);
  endtask

  task automatic rst_zero(input string tag);
    chk({tag, "_ctl_outs"}, 64'({trans_accept, trans_drop, lookup_req, drop_valid, miss_irq,
                                 drop_id, drop_len, miss_cnt}), 64'd0);
    chk({tag, "_addr_outs"}, {lookup_addr, miss_addr}, 64'd0);
  endtask

  // Monitor: every accept/drop pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pend) begin
        chk("sb_miss_cnt", 64'(miss_cnt), 64'(pend_cnt));
        chk("sb_miss_addr", 64'(miss_addr), 64'(pend_addr));
        pend = 1'b0;
      end
      if (trans_accept || trans_drop) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", 64'({trans_accept, trans_drop}), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_kind", 64'({trans_accept, trans_drop}), mon_e.is_drop ? 64'd1 : 64'd2);
          if (mon_e.is_drop) begin
            chk("sb_drop_id", 64'(drop_id), 64'(mon_e.id));
            chk("sb_drop_len", 64'(drop_len), 64'(mon_e.len));
            chk("sb_miss_irq", 64'(miss_irq), 64'd1);
            pend      = 1'b1;
            pend_cnt  = mon_e.cnt;
            pend_addr = mon_e.addr;
          end else begin
            chk("sb_accept_addr", 64'(lookup_addr), 64'(mon_e.addr));
          end
        end
      end
    end
  end

  initial begin
    pend        = 1'b0;
    trans_sent  = 1'b0;
    lookup_done = 1'b0;
    lookup_hit  = 1'b0;
    lookup_prot = 1'b0;
    drop_ready  = 1'b0;
    set_ar(1'b0, 32'h0, 4'h0, 8'h0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    rst_zero("reset");
    tick();
    rst_n = 1'b1;

    // Hit, result after 3 lookup cycles, sender handshakes in the accept cycle
    push_accept(32'h1000_0040);
    set_ar(1'b1, 32'h1000_0040, 4'h1, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin lookup_done = 1'b1; lookup_hit = 1'b1; end
      @(negedge clk);
      chk("t1_lookup_req", 64'(lookup_req), 64'd1);
      chk("t1_lookup_addr", 64'(lookup_addr), 64'h1000_0040);
      chk("t1_no_early_accept", 64'(trans_accept), 64'd0);
      tick();
    end
    lookup_done = 1'b0; lookup_hit = 1'b0; trans_sent = 1'b1;
    @(negedge clk);
    chk("t1_accept", 64'(trans_accept), 64'd1);
    chk("t1_req_off", 64'(lookup_req), 64'd0);
    tick();
    trans_sent = 1'b0;

    // Back-to-back AR: a hit at minimum latency, then 5 cycles of sender backpressure
    push_accept(32'h2000_0100);
    set_ar(1'b1, 32'h2000_0100, 4'h2, 8'h03);
    @(negedge clk);
    chk("t1_accept_single", 64'(trans_accept), 64'd0);
    chk("t1_miss_cnt", 64'(miss_cnt), 64'd0);
    tick();
    lookup_done = 1'b1; lookup_hit = 1'b1;
    @(negedge clk);
    chk("t2_req_b2b", 64'(lookup_req), 64'd1);
    tick();
    lookup_done = 1'b0; lookup_hit = 1'b0;
    @(negedge clk);
    chk("t2_accept", 64'(trans_accept), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("t2_wait_no_reaccept", 64'(trans_accept), 64'd0);
      chk("t2_wait_no_capture", 64'(lookup_req), 64'd0);
    end
    tick();
    trans_sent = 1'b1;
    @(negedge clk);
    chk("t2_sent_no_accept", 64'(trans_accept), 64'd0);
    tick();
    trans_sent = 1'b0;

    // Miss with drop_ready held low for 4 cycles
    push_drop(4'h5, 8'h07, 32'h3000_0200, 16'd1);
    set_ar(1'b1, 32'h3000_0200, 4'h5, 8'h07);
    tick();
    lookup_done = 1'b1; lookup_hit = 1'b0;
    @(negedge clk);
    chk("t3_req", 64'(lookup_req), 64'd1);
    tick();
    lookup_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_drop_valid", 64'(drop_valid), 64'd1);
      chk("t3_drop_id", 64'(drop_id), 64'h5);
      chk("t3_drop_len", 64'(drop_len), 64'h7);
      chk("t3_no_drop_yet", 64'({trans_drop, miss_irq}), 64'd0);
      tick();
    end
    drop_ready = 1'b1;
    @(negedge clk);
    chk("t3_trans_drop", 64'(trans_drop), 64'd1);
    chk("t3_miss_irq", 64'(miss_irq), 64'd1);
    tick();
    drop_ready = 1'b0;

    // Protection violation on a hit, responder already ready
    push_drop(4'h9, 8'h01, 32'h4000_0300, 16'd2);
    set_ar(1'b1, 32'h4000_0300, 4'h9, 8'h01);
    @(negedge clk);
    chk("t3_miss_cnt", 64'(miss_cnt), 64'd1);
    chk("t3_miss_addr", 64'(miss_addr), 64'h3000_0200);
    chk("t3_drop_cleared", 64'(drop_valid), 64'd0);
    tick();
    lookup_done = 1'b1; lookup_hit = 1'b1; lookup_prot = 1'b1;
    tick();
    lookup_done = 1'b0; lookup_hit = 1'b0; lookup_prot = 1'b0; drop_ready = 1'b1;
    @(negedge clk);
    chk("t4_drop_valid", 64'(drop_valid), 64'd1);
    chk("t4_trans_drop", 64'(trans_drop), 64'd1);
    chk("t4_no_accept", 64'(trans_accept), 64'd0);
    tick();
    drop_ready = 1'b0;

    // Timeout: no result, lookup_req for exactly 8 cycles
    push_drop(4'h3, 8'h02, 32'h5000_0400, 16'd3);
    set_ar(1'b1, 32'h5000_0400, 4'h3, 8'h02);
    @(negedge clk);
    chk("t4_miss_cnt", 64'(miss_cnt), 64'd2);
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t5_req_window", 64'(lookup_req), 64'd1);
      chk("t5_no_drop_early", 64'(drop_valid), 64'd0);
      tick();
    end
    drop_ready = 1'b1;
    @(negedge clk);
    chk("t5_req_ended", 64'(lookup_req), 64'd0);
    chk("t5_drop_valid", 64'(drop_valid), 64'd1);
    chk("t5_trans_drop", 64'(trans_drop), 64'd1);
    tick();
    drop_ready = 1'b0;

    // Result in the 8th lookup cycle beats the timeout
    push_accept(32'h6000_0500);
    set_ar(1'b1, 32'h6000_0500, 4'h4, 8'h04);
    @(negedge clk);
    chk("t5_miss_cnt", 64'(miss_cnt), 64'd3);
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin lookup_done = 1'b1; lookup_hit = 1'b1; end
      @(negedge clk);
      chk("t6_req_window", 64'(lookup_req), 64'd1);
      tick();
    end
    lookup_done = 1'b0; lookup_hit = 1'b0; trans_sent = 1'b1;
    @(negedge clk);
    chk("t6_accept", 64'(trans_accept), 64'd1);
    chk("t6_no_drop", 64'(drop_valid), 64'd0);
    tick();
    trans_sent = 1'b0;

    // Reset during LOOKUP, then a stale result
    set_ar(1'b1, 32'h7000_0600, 4'h6, 8'h05);
    tick();
    @(negedge clk);
    chk("t7_req", 64'(lookup_req), 64'd1);
    #1 rst_n = 1'b0;
    set_ar(1'b0, 32'h0, 4'h0, 8'h0);
    #1 rst_zero("t7_rst_lookup");
    repeat (2) tick();
    rst_n = 1'b1;
    lookup_done = 1'b1; lookup_hit = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t7_late_done_ignored", 64'({trans_accept, trans_drop, lookup_req, drop_valid}), 64'd0);
      chk("t7_miss_cnt_cleared", 64'(miss_cnt), 64'd0);
      tick();
    end
    lookup_done = 1'b0; lookup_hit = 1'b0;

    // Reset during DROP, then a stale result
    set_ar(1'b1, 32'h8000_0700, 4'h7, 8'h06);
    tick();
    lookup_done = 1'b1; lookup_hit = 1'b0;
    tick();
    lookup_done = 1'b0;
    @(negedge clk);
    chk("t8_drop_valid", 64'(drop_valid), 64'd1);
    chk("t8_drop_id", 64'(drop_id), 64'h7);
    #1 rst_n = 1'b0;
    set_ar(1'b0, 32'h0, 4'h0, 8'h0);
    #1 rst_zero("t8_rst_drop");
    repeat (2) tick();
    rst_n = 1'b1;
    lookup_done = 1'b1; lookup_prot = 1'b1; drop_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t8_late_done_ignored", 64'({trans_accept, trans_drop, lookup_req, drop_valid}), 64'd0);
      tick();
    end
    lookup_done = 1'b0; lookup_prot = 1'b0; drop_ready = 1'b0;

    // Normal operation resumes after reset
    push_accept(32'h9000_0800);
    set_ar(1'b1, 32'h9000_0800, 4'h8, 8'h00);
    tick();
    lookup_done = 1'b1; lookup_hit = 1'b1;
    tick();
    lookup_done = 1'b0; lookup_hit = 1'b0; trans_sent = 1'b1;
    @(negedge clk);
    chk("t9_accept", 64'(trans_accept), 64'd1);
    tick();
    trans_sent = 1'b0;
    set_ar(1'b0, 32'h0, 4'h0, 8'h0);
    repeat (2) tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
